// File: rtl/bits_pattern_gen.sv
// rtl/bits_pattern_gen.sv - burst pattern source of packed [CHANNELS][LANES][LANE_W] beats
// Four deterministic pattern modes, header struct per beat, valid/ready handshake.
module bits_pattern_gen #(
   parameter int          LANE_W   = 32,
   parameter int          LANES    = 2,
   parameter int          CHANNELS = 2,
   parameter logic [31:0] SEED     = 32'h19260817
) (
   input  logic                                        clk,
   input  logic                                        resetn,
   input  logic                                        start,
   input  logic [1:0]                                  mode,
   input  logic [15:0]                                 len,
   output logic [CHANNELS-1:0][LANES-1:0][LANE_W-1:0]  data,
   output logic [16:0]                                 hdr,
   output logic                                        valid,
   input  logic                                        ready,
   output logic                                        busy,
   output logic                                        done,
   output logic [31:0]                                 total
);

   typedef logic [CHANNELS-1:0][LANES-1:0][LANE_W-1:0] beat_t;
   typedef struct packed {
      logic        last;
      logic [15:0] beat;
   } hdr_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [31:0] POLY = 32'h80200003;

   state_t      state;
   logic [1:0]  mode_r;
   logic [15:0] len_r;
   logic [15:0] k;
   logic [31:0] lfsr;
   hdr_t        hdr_q;

   logic [15:0] k_nxt;
   logic [31:0] lfsr_nxt;
   beat_t       first_beat;
   beat_t       next_beat;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   // Element index is formed in 32 bits, then each mode truncates to the lane width.
   function automatic logic [LANE_W-1:0] elem(input logic [1:0] m, input logic [15:0] kk,
                                              input int c, input int l, input logic [31:0] lf);
      logic [31:0] i;
      logic [31:0] v;
      i = 32'(kk) * 32'(CHANNELS * LANES) + 32'(c * LANES + l);
      case (m)
         2'd0:    v = SEED;
         2'd1:    v = SEED + i;
         2'd2:    v = lf ^ i;
         default: v = 32'd1 << (i % 32'(LANE_W));
      endcase
      return LANE_W'(v);
   endfunction

   function automatic beat_t beat_of(input logic [1:0] m, input logic [15:0] kk,
                                     input logic [31:0] lf);
      beat_t d;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int l = 0; l < LANES; l++) begin
            d[c][l] = elem(m, kk, c, l, lf);
         end
      end
      return d;
   endfunction

   assign k_nxt      = k + 16'd1;
   assign lfsr_nxt   = lfsr_step(lfsr);
   assign first_beat = beat_of(mode, 16'd0, SEED);
   assign next_beat  = beat_of(mode_r, k_nxt, lfsr_nxt);
   assign hdr        = hdr_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         mode_r <= 2'd0;
         len_r  <= 16'd0;
         k      <= 16'd0;
         lfsr   <= SEED;
         hdr_q  <= '0;
         data   <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         total  <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_r <= mode;
                  len_r  <= len;
                  k      <= 16'd0;
                  lfsr   <= SEED;
                  if (len != 16'd0) begin
                     state <= S_RUN;
                     valid <= 1'b1;
                     busy  <= 1'b1;
                     data  <= first_beat;
                     hdr_q <= '{last: (len == 16'd1), beat: 16'd0};
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               // Without ready the beat is simply not touched, which keeps data/hdr stable.
               if (ready) begin
                  total <= total + 32'd1;
                  k     <= k_nxt;
                  lfsr  <= lfsr_nxt;
                  if (hdr_q.last) begin
                     state <= S_DONE;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     data  <= next_beat;
                     hdr_q <= '{last: (k_nxt == len_r - 16'd1), beat: k_nxt};
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bits_pattern_gen.sv
// tb/tb_bits_pattern_gen.sv - self-checking bench for bits_pattern_gen
module tb_bits_pattern_gen;

   localparam logic [31:0] SEED = 32'h19260817;
   localparam logic [31:0] POLY = 32'h80200003;

   typedef struct packed {
      logic        last;
      logic [15:0] beat;
   } hdr_t;

   logic                  clk = 1'b0;
   logic                  resetn;
   logic                  start;
   logic [1:0]            mode;
   logic [15:0]           len;
   logic [1:0][1:0][31:0] data;
   hdr_t                  hdr;
   logic                  valid;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic [31:0]           total;

   logic                  start8;
   logic [1:0]            mode8;
   logic [15:0]           len8;
   logic [1:0][1:0][7:0]  data8;
   hdr_t                  hdr8;
   logic                  valid8;
   logic                  ready8;
   logic                  busy8;
   logic                  done8;
   logic [31:0]           total8;

   int          checks  = 0;
   int          errors  = 0;
   int          total_m = 0;
   logic [31:0] cap [0:15][0:3];

   always #5 clk = ~clk;

   bits_pattern_gen dut (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode), .len(len),
      .data(data), .hdr(hdr), .valid(valid), .ready(ready), .busy(busy),
      .done(done), .total(total)
   );

   bits_pattern_gen #(.LANE_W(8)) dut8 (
      .clk(clk), .resetn(resetn), .start(start8), .mode(mode8), .len(len8),
      .data(data8), .hdr(hdr8), .valid(valid8), .ready(ready8), .busy(busy8),
      .done(done8), .total(total8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_lfsr(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   // Reference element: e is the flat position c*2+l inside a 2x2 beat.
   function automatic logic [31:0] m_elem(input int w, input logic [1:0] m, input int k,
                                          input int e, input logic [31:0] lf);
      logic [31:0] i;
      logic [31:0] v;
      i = 32'(k * 4 + e);
      case (m)
         2'd0:    v = SEED;
         2'd1:    v = SEED + i;
         2'd2:    v = lf ^ i;
         default: v = 32'd1 << (i % 32'(w));
      endcase
      if (w < 32) v = v & ((32'd1 << w) - 32'd1);
      return v;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the done pulse.
   task automatic run_burst(input logic [1:0] m, input int n, input int pct, input int stall_beat);
      int          k;
      int          budget;
      int          stalls;
      logic        r;
      logic [31:0] lf;
      k = 0; budget = 0; stalls = 0; lf = SEED;
      start = 1'b1; mode = m; len = 16'(n); ready = 1'b0;
      @(negedge clk);
      start = 1'b0; mode = 2'($urandom); len = 16'($urandom);
      while (k < n && budget < 2000) begin
         budget++;
         chk("valid", 32'(valid), 32'd1);
         chk("busy", 32'(busy), 32'd1);
         chk("done_in_run", 32'(done), 32'd0);
         chk("hdr_beat", 32'(hdr.beat), 32'(k));
         chk("hdr_last", 32'(hdr.last), 32'(k == n - 1));
         chk("total", total, 32'(total_m));
         for (int e = 0; e < 4; e++) begin
            chk("data", data[e / 2][e % 2], m_elem(32, m, k, e, lf));
            if (k < 16) cap[k][e] = data[e / 2][e % 2];
         end
         if (k == stall_beat && stalls < 3) begin
            r = 1'b0; stalls++;
            start = 1'b1; mode = 2'($urandom); len = 16'($urandom);
         end else begin
            r = ($urandom_range(99) >= pct);
            start = 1'b0;
         end
         ready = r;
         @(negedge clk);
         if (r) begin
            k++; total_m++; lf = m_lfsr(lf);
         end
      end
      chk("beats_sent", 32'(k), 32'(n));
      ready = 1'b0; start = 1'b0;
      chk("done", 32'(done), 32'd1);
      chk("valid_after", 32'(valid), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("total_end", total, 32'(total_m));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; ready = 1'b0; mode = 2'd0; len = 16'd0;
      start8 = 1'b0; ready8 = 1'b1; mode8 = 2'd0; len8 = 16'd0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_total", total, 32'd0);
      chk("rst_hdr", 32'(hdr), 32'd0);
      for (int e = 0; e < 4; e++) chk("rst_data", data[e / 2][e % 2], 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      run_burst(2'd1, 2, 0, -1);
      chk("inc_b0_00", cap[0][0], 32'h19260817);
      chk("inc_b0_01", cap[0][1], 32'h19260818);
      chk("inc_b0_10", cap[0][2], 32'h19260819);
      chk("inc_b0_11", cap[0][3], 32'h1926081a);
      chk("inc_b1_00", cap[1][0], 32'h1926081b);
      chk("inc_total", total, 32'd2);

      run_burst(2'd2, 2, 0, -1);
      chk("lfsr_b0_00", cap[0][0], 32'h19260817);
      chk("lfsr_b0_11", cap[0][3], 32'h19260814);
      chk("lfsr_b1_00", cap[1][0], 32'h8cb3040c);

      run_burst(2'd3, 9, 0, -1);
      chk("walk_b0_11", cap[0][3], 32'h00000008);
      chk("walk_b8_00", cap[8][0], 32'h00000001);
      chk("walk_b7_11", cap[7][3], 32'h80000000);

      run_burst(2'd1, 5, 0, 1);
      run_burst(2'd2, 0, 0, -1);
      repeat (6) run_burst(2'($urandom_range(3)), int'($urandom_range(20, 1)), 30, -1);

      start = 1'b1; mode = 2'd1; len = 16'd8; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_beat", 32'(hdr.beat), 32'd3);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_total", total, 32'd0);
      total_m = 0;
      @(negedge clk);
      resetn = 1'b1; ready = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 32'(valid), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      run_burst(2'd1, 3, 0, -1);
      chk("restart_seed", cap[0][0], SEED);

      start8 = 1'b1; mode8 = 2'd1; len8 = 16'd59;
      @(negedge clk);
      start8 = 1'b0;
      for (int k = 0; k < 59; k++) begin
         chk("w8_valid", 32'(valid8), 32'd1);
         chk("w8_beat", 32'(hdr8.beat), 32'(k));
         for (int e = 0; e < 4; e++) chk("w8_data", 32'(data8[e / 2][e % 2]), m_elem(8, 2'd1, k, e, SEED));
         if (k == 0)  chk("w8_b0_00", 32'(data8[0][0]), 32'h17);
         if (k == 58) chk("w8_i233", 32'(data8[0][1]), 32'h00);
         @(negedge clk);
      end
      chk("w8_done", 32'(done8), 32'd1);
      chk("w8_total", total8, 32'd59);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
